vocab_match_ctrl: RTL and testbench
===================================

Name: vocab_match_ctrl

Overview:
- Sequencer for the word-lookup datapath: walks the vocabulary SRAM entry by entry and the input-word SRAM byte by byte.
- Compares the returned bytes and reports the index of the first vocabulary entry equal to the input word.
- Sits between the two read-only synchronous SRAMs and the downstream encoder logic.
- Owns both SRAM address buses and chip selects.

Parameters:
- ADDR_WIDTH, 4: SRAM address width.
- DATA_WIDTH, 8: SRAM data width, one character per word.
- WORD_LEN, 4: characters per vocabulary entry and per input word. Fixed length, no terminator.
- NUM_ENTRIES, 4: vocabulary entries. Requires NUM_ENTRIES*WORD_LEN <= 2**ADDR_WIDTH and WORD_LEN <= 2**ADDR_WIDTH.
- IDX_W, max(1,$clog2(NUM_ENTRIES)): width of match_idx. Derived, not overridden.

Ports:
- clk, input, 1: clock. All state changes on the rising edge.
- rst, input, 1: synchronous active-high reset.
- start, input, 1: lookup request. Sampled only in IDLE.
- busy, output, 1: high in FETCH and CMP.
- done, output, 1: one-cycle pulse at lookup end.
- found, output, 1: last lookup matched.
- match_idx, output, IDX_W: index of the matching entry.
- addr_v, output, ADDR_WIDTH: vocab SRAM address.
- addr_i, output, ADDR_WIDTH: input SRAM address.
- vocab_cs, output, 1: vocab SRAM chip select.
- input_cs, output, 1: input SRAM chip select.
- vocab_dout, input, DATA_WIDTH: vocab SRAM read data. Valid the cycle after the address is sampled with cs=1.
- input_dout, input, DATA_WIDTH: input SRAM read data. Same timing as vocab_dout.

Behaviour:
- Clock is clk. Reset is rst, synchronous, active-high.
- Reset values: state=IDLE; entry and byte counters 0; busy=0; done=0; found=0; match_idx=0; addr_v=0; addr_i=0; vocab_cs=0; input_cs=0.
- Counters:
  - entry: 0..NUM_ENTRIES-1.
  - byte: 0..WORD_LEN-1.
- Addresses are combinational from the counters and stable through FETCH and CMP:
  - addr_v = entry*WORD_LEN + byte, computed at ADDR_WIDTH bits. No wrap is possible given the parameter constraint.
  - addr_i = byte.
- FSM states: IDLE, FETCH, CMP, DONE.
- IDLE:
  - start=1 → entry=0, byte=0, found=0, match_idx=0; go to FETCH.
  - start=0 → stay in IDLE.
- FETCH:
  - vocab_cs=input_cs=1. The SRAMs sample the addresses at the end of the cycle.
  - Next state: CMP.
- CMP:
  - cs=0; vocab_dout and input_dout are valid.
  - Bytes equal and byte==WORD_LEN-1 → found=1, match_idx=entry; go to DONE.
  - Bytes equal and byte<WORD_LEN-1 → byte++; go to FETCH.
  - Bytes differ and entry==NUM_ENTRIES-1 → found=0; go to DONE.
  - Bytes differ otherwise → entry++, byte=0; go to FETCH. This is an early abort of the current entry.
- DONE:
  - done=1 for exactly one cycle, busy=0.
  - Next state: IDLE.
  - start during DONE is ignored.
- found and match_idx hold from DONE until the next accepted start, which clears both.
- start while busy (FETCH/CMP) or in DONE: ignored, no effect.
- Duplicate vocabulary entries: the lowest index wins and the scan stops at the first full match.
- Latency: let K be the total byte comparisons performed.
  - With start sampled at edge 0, busy is high cycles 1..2K.
  - done is high in cycle 2K+1.
  - The next start is accepted at the earliest at edge 2K+2.
- Bounds: K ranges from WORD_LEN (match at entry 0) to NUM_ENTRIES*WORD_LEN (every entry mismatches on its last byte).
- Reset mid-lookup: at the next edge return to IDLE with reset values. No done pulse is emitted.
- rst and start high together: reset wins.

Test Plan:
- Basic match:
  - Stimulus: WORD_LEN=4, NUM_ENTRIES=4; vocab = 61626364, 65666768, 6B6C6D6E, 70717273; input = 6B6C6D6E; start pulse at edge 0.
  - Required: K=6; busy in cycles 1–12; done in cycle 13; found=1, match_idx=2.
- No match:
  - Stimulus: input = 70717274.
  - Required: entries 0–2 abort at byte 0, entry 3 at byte 3; K=7; done in cycle 15; found=0, match_idx=0.
- Duplicate entries:
  - Stimulus: entries 1 and 3 both 65666768; input = 65666768.
  - Required: K=5; done in cycle 11; match_idx=1.
- Addressing trace for the basic-match case:
  - Required: in FETCH cycles, addr_v sequence is 0, 4, 8, 9, 10, 11; addr_i sequence is 0, 0, 0, 1, 2, 3.
  - Required: vocab_cs and input_cs are high only in FETCH cycles.
- start while busy:
  - Stimulus: start pulses in cycles 3 and 13 of the basic-match lookup.
  - Required: ignored; the single done in cycle 13 still carries match_idx=2; a start at edge 14 begins a new lookup.
- Reset mid-lookup:
  - Stimulus: rst=1 in cycle 5.
  - Required: from cycle 6, busy=0, state IDLE, all outputs at reset values; done never asserts.

Source files
------------

// File: rtl/vocab_match_ctrl.sv
// Word-lookup sequencer: scans vocabulary SRAM entries byte by byte against the
// input-word SRAM and reports the index of the first fully matching entry.
module vocab_match_ctrl #(
    parameter  int ADDR_WIDTH  = 4,
    parameter  int DATA_WIDTH  = 8,
    parameter  int WORD_LEN    = 4,
    parameter  int NUM_ENTRIES = 4,
    localparam int IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  found,
    output logic [IDX_W-1:0]      match_idx,
    output logic [ADDR_WIDTH-1:0] addr_v,
    output logic [ADDR_WIDTH-1:0] addr_i,
    output logic                  vocab_cs,
    output logic                  input_cs,
    input  logic [DATA_WIDTH-1:0] vocab_dout,
    input  logic [DATA_WIDTH-1:0] input_dout
);

    localparam int BYTE_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
    localparam logic [ADDR_WIDTH-1:0] WORD_LEN_A = ADDR_WIDTH'(WORD_LEN);
    localparam logic [BYTE_W-1:0]     LAST_BYTE  = BYTE_W'(WORD_LEN - 1);
    localparam logic [IDX_W-1:0]      LAST_ENTRY = IDX_W'(NUM_ENTRIES - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        CMP,
        DONE
    } state_t;

    state_t            state, state_next;
    logic [IDX_W-1:0]  entry_cnt, entry_next;
    logic [BYTE_W-1:0] byte_cnt, byte_next;
    logic              found_q, found_next;
    logic [IDX_W-1:0]  idx_q, idx_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            entry_cnt <= '0;
            byte_cnt  <= '0;
            found_q   <= 1'b0;
            idx_q     <= '0;
        end else begin
            state     <= state_next;
            entry_cnt <= entry_next;
            byte_cnt  <= byte_next;
            found_q   <= found_next;
            idx_q     <= idx_next;
        end
    end

    always_comb begin
        state_next = state;
        entry_next = entry_cnt;
        byte_next  = byte_cnt;
        found_next = found_q;
        idx_next   = idx_q;
        unique case (state)
            IDLE: begin
                if (start) begin
                    entry_next = '0;
                    byte_next  = '0;
                    found_next = 1'b0;
                    idx_next   = '0;
                    state_next = FETCH;
                end
            end
            FETCH: state_next = CMP;
            CMP: begin
                // A byte mismatch abandons the current entry immediately.
                if (vocab_dout == input_dout) begin
                    if (byte_cnt == LAST_BYTE) begin
                        found_next = 1'b1;
                        idx_next   = entry_cnt;
                        state_next = DONE;
                    end else begin
                        byte_next  = byte_cnt + 1'b1;
                        state_next = FETCH;
                    end
                end else if (entry_cnt == LAST_ENTRY) begin
                    found_next = 1'b0;
                    state_next = DONE;
                end else begin
                    entry_next = entry_cnt + 1'b1;
                    byte_next  = '0;
                    state_next = FETCH;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy      = (state == FETCH) || (state == CMP);
    assign done      = (state == DONE);
    assign vocab_cs  = (state == FETCH);
    assign input_cs  = (state == FETCH);
    assign found     = found_q;
    assign match_idx = idx_q;
    assign addr_v    = ADDR_WIDTH'(entry_cnt) * WORD_LEN_A + ADDR_WIDTH'(byte_cnt);
    assign addr_i    = ADDR_WIDTH'(byte_cnt);

endmodule

// File: tb/tb_vocab_match_ctrl.sv
// Self-checking bench for vocab_match_ctrl: directed test-plan cases plus random
// lookups, each checked cycle by cycle against a behavioural scan model.
module tb_vocab_match_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int WL = 4;
    localparam int NE = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          found;
    logic [IW-1:0] match_idx;
    logic [AW-1:0] addr_v;
    logic [AW-1:0] addr_i;
    logic          vocab_cs;
    logic          input_cs;
    logic [DW-1:0] vocab_dout = '0;
    logic [DW-1:0] input_dout = '0;

    logic [DW-1:0] vmem [2**AW];
    logic [DW-1:0] imem [2**AW];
    logic [31:0]   vw [NE];
    logic [31:0]   iw;

    int n_checks = 0;
    int n_pass   = 0;

    vocab_match_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .WORD_LEN   (WL),
        .NUM_ENTRIES(NE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .found     (found),
        .match_idx (match_idx),
        .addr_v    (addr_v),
        .addr_i    (addr_i),
        .vocab_cs  (vocab_cs),
        .input_cs  (input_cs),
        .vocab_dout(vocab_dout),
        .input_dout(input_dout)
    );

    always #5 clk = ~clk;

    // Synchronous-read SRAM models: data appears the cycle after a selected address.
    always @(posedge clk) begin
        if (vocab_cs) vocab_dout <= vmem[addr_v];
        if (input_cs) input_dout <= imem[addr_i];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic load_words();
        for (int e = 0; e < NE; e++)
            for (int b = 0; b < WL; b++)
                vmem[e*WL + b] = vw[e][8*(WL-1-b) +: 8];
        for (int b = 0; b < WL; b++)
            imem[b] = iw[8*(WL-1-b) +: 8];
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_done"},  32'(done), 0);
        check({tag, "_found"}, 32'(found), 0);
        check({tag, "_idx"},   32'(match_idx), 0);
        check({tag, "_addrv"}, 32'(addr_v), 0);
        check({tag, "_addri"}, 32'(addr_i), 0);
        check({tag, "_vcs"},   32'(vocab_cs), 0);
        check({tag, "_ics"},   32'(input_cs), 0);
    endtask

    // busy_starts: extra start pulses in cycles 3 and 13. rst_cycle: assert rst in that cycle (0 = none).
    task automatic run_lookup(input string tag, input bit busy_starts, input int rst_cycle);
        int     k = 0;
        bit     hit = 0;
        int     idx = 0;
        bit     aborted = 0;
        int     qv[$];
        int     qi[$];
        int     j;
        // Reference scan: lowest matching entry wins, mismatch aborts an entry.
        for (int e = 0; e < NE && !hit; e++) begin
            for (int b = 0; b < WL; b++) begin
                k++;
                qv.push_back(e*WL + b);
                qi.push_back(b);
                if (vw[e][8*(WL-1-b) +: 8] != iw[8*(WL-1-b) +: 8]) break;
                if (b == WL-1) begin
                    hit = 1;
                    idx = e;
                end
            end
        end
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 1; c <= 2*k + 2; c++) begin
            if (aborted) begin
                check_reset_outputs({tag, "_postrst"});
            end else if (c <= 2*k) begin
                j = (c - 1) / 2;
                check({tag, "_busy"},  32'(busy), 1);
                check({tag, "_done"},  32'(done), 0);
                check({tag, "_vcs"},   32'(vocab_cs), 32'(c % 2));
                check({tag, "_ics"},   32'(input_cs), 32'(c % 2));
                check({tag, "_addrv"}, 32'(addr_v), 32'(qv[j]));
                check({tag, "_addri"}, 32'(addr_i), 32'(qi[j]));
                check({tag, "_fclr"},  32'(found), 0);
                check({tag, "_iclr"},  32'(match_idx), 0);
            end else if (c == 2*k + 1) begin
                check({tag, "_dbusy"}, 32'(busy), 0);
                check({tag, "_done"},  32'(done), 1);
                check({tag, "_dvcs"},  32'(vocab_cs), 0);
                check({tag, "_found"}, 32'(found), 32'(hit));
                check({tag, "_idx"},   32'(match_idx), 32'(idx));
            end else begin
                check({tag, "_ibusy"}, 32'(busy), 0);
                check({tag, "_idone"}, 32'(done), 0);
                check({tag, "_hfound"}, 32'(found), 32'(hit));
                check({tag, "_hidx"},  32'(match_idx), 32'(idx));
            end
            rst   = (rst_cycle != 0 && c == rst_cycle);
            if (rst) aborted = 1;
            start = (c < 2*k + 2) && busy_starts && (c == 3 || c == 13);
            if (c < 2*k + 2) begin
                @(posedge clk);
                #1;
            end
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        for (int a = 0; a < 2**AW; a++) begin
            vmem[a] = '0;
            imem[a] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");

        // Reset wins over a simultaneous start.
        start = 1'b1;
        @(posedge clk);
        #1;
        check("rst_start_busy", 32'(busy), 0);
        start = 1'b0;
        rst   = 1'b0;
        @(posedge clk);
        #1;
        check("idle_busy", 32'(busy), 0);

        vw[0] = 32'h61626364;
        vw[1] = 32'h65666768;
        vw[2] = 32'h6B6C6D6E;
        vw[3] = 32'h70717273;
        iw    = 32'h6B6C6D6E;
        load_words();
        run_lookup("basic", 1'b0, 0);
        run_lookup("busy_start", 1'b1, 0);
        // Back-to-back: start accepted at the earliest edge after DONE.
        run_lookup("b2b", 1'b0, 0);

        iw = 32'h70717274;
        load_words();
        run_lookup("nomatch", 1'b0, 0);

        vw[3] = 32'h65666768;
        iw    = 32'h65666768;
        load_words();
        run_lookup("dup", 1'b0, 0);

        vw[3] = 32'h70717273;
        iw    = 32'h6B6C6D6E;
        load_words();
        run_lookup("midrst", 1'b0, 5);
        @(posedge clk);
        #1;
        check_reset_outputs("after_midrst");

        for (int n = 0; n < 30; n++) begin
            for (int e = 0; e < NE; e++)
                for (int b = 0; b < WL; b++)
                    vw[e][8*b +: 8] = 8'h61 + 8'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                iw = vw[$urandom_range(0, NE-1)];
            end else begin
                for (int b = 0; b < WL; b++)
                    iw[8*b +: 8] = 8'h61 + 8'($urandom_range(0, 1));
            end
            load_words();
            run_lookup("rand", 1'($urandom_range(0, 1)), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
